// File: rtl/rx_pkt_pkg.sv
// ============================================================================
// rx_pkt_pkg : shared constants, descriptor field layout and FSM state type
//              for the RX packet summarizer.
// Revision   : 1.0
// ============================================================================
`default_nettype none

package rx_pkt_pkg;

    // Reference frame sizes in bytes (full-size, medium, flow-control)
    localparam int FD_LENGTH = 4160;
    localparam int MD_LENGTH = 192;
    localparam int FC_LENGTH = 68;

    localparam int LEN_LSB  = 0;
    localparam int LEN_W    = 16;
    localparam int PORT_LSB = 16;
    localparam int PORT_W   = 8;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BODY = 1'b1
    } state_t;

endpackage : rx_pkt_pkg

`default_nettype wire

// File: rtl/rx_pkt_summarizer_tkeep_count.sv
// ============================================================================
// tkeep_count : combinational popcount of a byte-enable vector plus a flag
//               telling whether the enables form a run of ones from bit 0.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tkeep_count
    import rx_pkt_pkg::*;
#(
    parameter int KW = 64
) (
    input  logic [KW-1:0]       i_keep,
    output logic [$clog2(KW):0] o_count,
    output logic                o_contig
);

    localparam int CW = $clog2(KW) + 1;

    logic [CW-1:0] w_count;
    logic [KW:0]   w_mask;

    always_comb begin
        w_count = '0;
        for (int i = 0; i < KW; i++) begin
            w_count = w_count + CW'(i_keep[i]);
        end
    end

    // (1 << count) - 1 in KW+1 bits so a fully set vector still fits
    assign w_mask   = ({{KW{1'b0}}, 1'b1} << w_count) - {{KW{1'b0}}, 1'b1};
    assign o_count  = w_count;
    assign o_contig = (w_mask == {1'b0, i_keep});

endmodule : tkeep_count

`default_nettype wire

// File: rtl/rx_pkt_summarizer.sv
// ============================================================================
// rx_pkt_summarizer : turns a wide AXI-Stream packet bus into one 24-bit
//                     {port, length} descriptor per packet with a bad flag.
//                     Optional runt check: RX_SUMMARIZER_RUNT_CHECK_EN.
// Revision          : 1.0
// ============================================================================
`default_nettype none

module rx_pkt_summarizer
    import rx_pkt_pkg::*;
#(
    parameter int DW          = 512,
    parameter int SW          = 24,
    parameter int PORT_OFFSET = 14,
    parameter int MIN_LEN     = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [DW-1:0]   axis_in_tdata,
    input  logic [DW/8-1:0] axis_in_tkeep,
    input  logic            axis_in_tlast,
    input  logic            axis_in_tuser,
    input  logic            axis_in_tvalid,
    output logic            axis_in_tready,
    output logic [SW-1:0]   axis_out_tdata,
    output logic            axis_out_tuser,
    output logic            axis_out_tvalid
);

    localparam int KW = DW / 8;
    localparam int CW = $clog2(KW) + 1;

    if ((DW % 8) != 0 || PORT_OFFSET >= KW || SW != 24 ||
        MIN_LEN < 0 || MIN_LEN > 65535) begin : g_bad_param
        $error("rx_pkt_summarizer: illegal parameter combination");
    end

    state_t              r_state;
    logic                r_tready;
    logic [LEN_W-1:0]    r_len;
    logic                r_bad;
    logic [PORT_W-1:0]   r_port;
    logic                r_out_valid;
    logic [SW-1:0]       r_out_data;
    logic                r_out_user;

    logic [CW-1:0]       w_count;
    logic                w_contig;
    logic                w_accept;
    logic [LEN_W-1:0]    w_len_base;
    logic [LEN_W:0]      w_sum;
    logic [LEN_W-1:0]    w_len_next;
    logic                w_beat_bad;
    logic                w_bad_next;
    logic                w_runt;
    logic                w_bad_final;
    logic [PORT_W-1:0]   w_port_beat;
    logic [PORT_W-1:0]   w_port_cur;
    logic [SW-1:0]       w_desc;
    logic                w_unused;

    tkeep_count #(
        .KW       (KW)
    ) u_tkeep_count (
        .i_keep   (axis_in_tkeep),
        .o_count  (w_count),
        .o_contig (w_contig)
    );

    assign w_accept    = axis_in_tvalid && r_tready;
    assign w_port_beat = axis_in_tdata[PORT_OFFSET*8 +: PORT_W];
    assign w_port_cur  = (r_state == S_IDLE) ? w_port_beat : r_port;
    assign w_unused    = &{1'b0, axis_in_tdata};

    // A packet start begins from zero rather than relying on cleared state
    assign w_len_base  = (r_state == S_IDLE) ? '0 : r_len;
    assign w_sum       = {1'b0, w_len_base} + (LEN_W+1)'(w_count);
    assign w_len_next  = w_sum[LEN_W] ? {LEN_W{1'b1}} : w_sum[LEN_W-1:0];

    assign w_beat_bad  = axis_in_tuser
                       || (!axis_in_tlast && (axis_in_tkeep != {KW{1'b1}}))
                       || ( axis_in_tlast && (!w_contig || (w_count == '0)))
                       || w_sum[LEN_W];
    assign w_bad_next  = ((r_state == S_BODY) && r_bad) || w_beat_bad;

`ifdef RX_SUMMARIZER_RUNT_CHECK_EN
    assign w_runt      = (int'(w_len_next) < MIN_LEN);
`else
    assign w_runt      = 1'b0;
`endif

    assign w_bad_final = w_bad_next || w_runt;

    always_comb begin
        w_desc = '0;
        w_desc[LEN_LSB  +: LEN_W]  = w_len_next;
        w_desc[PORT_LSB +: PORT_W] = w_port_cur;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_tready    <= 1'b0;
            r_len       <= '0;
            r_bad       <= 1'b0;
            r_port      <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_user  <= 1'b0;
        end else begin
            r_tready    <= 1'b1;
            r_out_valid <= 1'b0;
            if (w_accept) begin
                r_len <= w_len_next;
                r_bad <= w_bad_next;
                if (r_state == S_IDLE) begin
                    r_port <= w_port_beat;
                end
                if (axis_in_tlast) begin
                    r_out_valid <= 1'b1;
                    r_out_data  <= w_desc;
                    r_out_user  <= w_bad_final;
                    r_state     <= S_IDLE;
                end else begin
                    r_state     <= S_BODY;
                end
            end
        end
    end

    assign axis_in_tready  = r_tready;
    assign axis_out_tdata  = r_out_data;
    assign axis_out_tuser  = r_out_user;
    assign axis_out_tvalid = r_out_valid;

endmodule : rx_pkt_summarizer

`default_nettype wire

// File: tb/tb_rx_pkt_summarizer.sv
// ============================================================================
// tb_rx_pkt_summarizer : directed and randomized bench for rx_pkt_summarizer,
//                        honours RX_SUMMARIZER_RUNT_CHECK_EN in its model.
// Revision             : 1.0
// ============================================================================
`default_nettype none

module tb_rx_pkt_summarizer;

    localparam int DW = 512;
    localparam int KW = DW / 8;

    typedef struct {
        logic [23:0] data;
        logic        user;
        int          cyc;
    } desc_t;

    logic            clk = 1'b0;
    logic            reset;
    logic [DW-1:0]   tdata;
    logic [KW-1:0]   tkeep;
    logic            tlast;
    logic            tuser;
    logic            tvalid;
    logic            tready;
    logic [23:0]     out_tdata;
    logic            out_tuser;
    logic            out_tvalid;

    int              cyc = 0;
    int              tests = 0;
    int              fails = 0;
    desc_t           exp_q[$];
    desc_t           obs_q[$];
    logic [KW-1:0]   pk_keep[$];
    bit              pk_user[$];
    logic [23:0]     last_data;
    bit              have_last = 0;

    rx_pkt_summarizer #(
        .DW              (DW),
        .SW              (24),
        .PORT_OFFSET     (14),
        .MIN_LEN         (64)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .axis_in_tdata   (tdata),
        .axis_in_tkeep   (tkeep),
        .axis_in_tlast   (tlast),
        .axis_in_tuser   (tuser),
        .axis_in_tvalid  (tvalid),
        .axis_in_tready  (tready),
        .axis_out_tdata  (out_tdata),
        .axis_out_tuser  (out_tuser),
        .axis_out_tvalid (out_tvalid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (out_tvalid === 1'b1) obs_q.push_back('{out_tdata, out_tuser, cyc});
    end

    function automatic logic [KW-1:0] ones(input int n);
        logic [KW-1:0] k;
        k = '0;
        for (int i = 0; i < n; i++) k[i] = 1'b1;
        return k;
    endfunction

    function automatic bit is_prefix(input logic [KW-1:0] k);
        bit seen_zero = 0;
        if (k == '0) return 0;
        for (int b = 0; b < KW; b++) begin
            if (!k[b]) seen_zero = 1;
            else if (seen_zero) return 0;
        end
        return 1;
    endfunction

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] d;
        for (int i = 0; i < DW/32; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        tests++;
        assert (got === want) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, want);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (tready !== 1'b1 && n < 20) begin
            step(1);
            n++;
        end
        chk("tready_rise", {31'd0, tready}, 32'd1);
    endtask

    // Sends the packet held in pk_keep/pk_user and records what it should yield
    task automatic run_pkt(input logic [7:0] port, input int gap_max);
        int          total = 0;
        bit          bad = 0;
        int          n = pk_keep.size();
        logic [DW-1:0] d;
        logic [15:0] len;
        for (int i = 0; i < n; i++) begin
            total += $countones(pk_keep[i]);
            if (pk_user[i]) bad = 1;
            if (i < n-1 && pk_keep[i] != {KW{1'b1}}) bad = 1;
            if (i == n-1 && !is_prefix(pk_keep[i])) bad = 1;
        end
        if (total > 65535) begin
            len = 16'hFFFF;
            bad = 1;
        end else begin
            len = 16'(total);
        end
`ifdef RX_SUMMARIZER_RUNT_CHECK_EN
        if (total < 64) bad = 1;
`endif
        for (int i = 0; i < n; i++) begin
            d = rand_data();
            if (i == 0) d[14*8 +: 8] = port;
            tdata  = d;
            tkeep  = pk_keep[i];
            tuser  = pk_user[i];
            tlast  = (i == n-1);
            tvalid = 1'b1;
            step(1);
            tvalid = 1'b0;
            tlast  = 1'b0;
            tuser  = 1'b0;
            if (i < n-1 && gap_max > 0) step($urandom_range(gap_max, 0));
        end
        exp_q.push_back('{{port, len}, bad, cyc});
        pk_keep.delete();
        pk_user.delete();
    endtask

    task automatic check_desc(input string tag);
        desc_t o;
        desc_t e;
        step(3);
        chk({tag, "_count"}, obs_q.size(), exp_q.size());
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            chk({tag, "_tdata"}, {8'd0, o.data}, {8'd0, e.data});
            chk({tag, "_tuser"}, {31'd0, o.user}, {31'd0, e.user});
            chk({tag, "_latency"}, o.cyc, e.cyc);
            last_data = e.data;
            have_last = 1;
        end
        exp_q.delete();
        obs_q.delete();
        if (have_last) chk({tag, "_hold"}, {8'd0, out_tdata}, {8'd0, last_data});
        chk({tag, "_strobe_low"}, {31'd0, out_tvalid}, 32'd0);
    endtask

    task automatic full_beats(input int n);
        for (int i = 0; i < n; i++) begin
            pk_keep.push_back({KW{1'b1}});
            pk_user.push_back(1'b0);
        end
    endtask

    task automatic add_beat(input logic [KW-1:0] k, input bit u);
        pk_keep.push_back(k);
        pk_user.push_back(u);
    endtask

    initial begin
        int nb;
        int sel;
        logic [KW-1:0] k;
        reset  = 1'b1;
        tdata  = '0;
        tkeep  = '0;
        tlast  = 1'b0;
        tuser  = 1'b0;
        tvalid = 1'b0;
        step(3);
        chk("rst_tready", {31'd0, tready}, 32'd0);
        chk("rst_tvalid", {31'd0, out_tvalid}, 32'd0);
        chk("rst_tdata", {8'd0, out_tdata}, 32'd0);
        chk("rst_tuser", {31'd0, out_tuser}, 32'd0);
        reset = 1'b0;
        wait_ready();

        // Full-size packet, port 5
        full_beats(65);
        run_pkt(8'h05, 0);
        check_desc("fd");

        // Flow-control packet then medium packet back to back
        full_beats(1);
        add_beat(ones(4), 1'b0);
        run_pkt(8'h01, 0);
        full_beats(3);
        run_pkt(8'h01, 0);
        check_desc("fc_md");

        // Upstream error mid-packet, then a non-contiguous last keep
        add_beat({KW{1'b1}}, 1'b0);
        add_beat({KW{1'b1}}, 1'b1);
        add_beat({KW{1'b1}}, 1'b0);
        run_pkt(8'h22, 1);
        full_beats(2);
        add_beat(64'h5, 1'b0);
        run_pkt(8'h33, 0);
        add_beat('0, 1'b0);
        run_pkt(8'h44, 0);
        check_desc("bad");

        // Length saturation, then a normal packet
        full_beats(1026);
        run_pkt(8'h7E, 0);
        full_beats(1);
        add_beat(ones(4), 1'b0);
        run_pkt(8'h7F, 0);
        check_desc("sat");

        // Reset partway through a full-size packet
        for (int i = 0; i < 10; i++) begin
            tdata  = rand_data();
            tkeep  = {KW{1'b1}};
            tvalid = 1'b1;
            step(1);
        end
        tvalid = 1'b0;
        reset  = 1'b1;
        #1;
        chk("midrst_tready", {31'd0, tready}, 32'd0);
        chk("midrst_tdata", {8'd0, out_tdata}, 32'd0);
        step(2);
        chk("midrst_tready_hold", {31'd0, tready}, 32'd0);
        reset = 1'b0;
        have_last = 0;
        wait_ready();
        full_beats(1);
        add_beat(ones(4), 1'b0);
        run_pkt(8'h09, 0);
        check_desc("after_rst");

        // Runt-sized single beat
        add_beat(ones(40), 1'b0);
        run_pkt(8'h0A, 0);
        check_desc("runt");

        // Randomized traffic with gaps and occasional errors
        for (int p = 0; p < 40; p++) begin
            nb = $urandom_range(6, 1);
            for (int b = 0; b < nb; b++) begin
                if (b < nb-1) begin
                    k = ($urandom_range(7, 0) == 0) ? {$urandom, $urandom} : {KW{1'b1}};
                end else begin
                    sel = $urandom_range(15, 0);
                    if (sel == 0)      k = '0;
                    else if (sel < 4)  k = {$urandom, $urandom};
                    else               k = ones($urandom_range(KW, 1));
                end
                add_beat(k, $urandom_range(15, 0) == 0);
            end
            run_pkt(8'($urandom), 2);
            if ($urandom_range(1, 0) == 1) step($urandom_range(2, 1));
        end
        check_desc("rand");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_rx_pkt_summarizer

`default_nettype wire
